// File: rtl/tank_pkg.sv
// Shared constants and types for the per-tank motion stage.
// Directions, command bit layout, default geometry, FSM encoding and the neighbour-cell helper.
package tank_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int CMD_GO = 2;

  localparam int CELL_PX_DEF  = 9;
  localparam int GRID_MAX_DEF = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [4:0] x;
    logic signed [4:0] y;
  } cell_s_t;

  // Signed 5-bit result so that 0-1 shows up as -1 rather than wrapping to 15.
  function automatic cell_s_t neighbour(input logic [3:0] cx, input logic [3:0] cy,
                                        input logic [1:0] dir);
    cell_s_t n;
    n.x = $signed({1'b0, cx});
    n.y = $signed({1'b0, cy});
    case (dir)
      DIR_UP:    n.y = n.y - 5'sd1;
      DIR_DOWN:  n.y = n.y + 5'sd1;
      DIR_LEFT:  n.x = n.x - 5'sd1;
      DIR_RIGHT: n.x = n.x + 5'sd1;
      default: ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tank_mover_tick_divider.sv
// Prescaler: emits a one-cycle step strobe on every STEP_DIV-th tick.
// The strobe is combinational so a step lands on the same edge as the tick that completes the count.
module tick_divider #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_step
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_step = i_tick && w_wrap && !i_clear;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tank_mover.sv
// Per-tank motion stage: accepts a one-cell move command and animates the tank pixel by pixel.
// Reports pixel position, facing, a busy flag and the source/target cells for collision checks.
module tank_mover
  import tank_pkg::*;
#(
  parameter int CELL_PX  = CELL_PX_DEF,
  parameter int GRID_MAX = GRID_MAX_DEF,
  parameter int INIT_GX  = 0,
  parameter int INIT_GY  = 0,
  parameter int INIT_DIR = 0,
  parameter int STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic [2:0] cmd,
  input  logic       kill,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic [1:0] facing,
  output logic       moving,
  output logic [3:0] cell_ax,
  output logic [3:0] cell_ay,
  output logic [3:0] cell_bx,
  output logic [3:0] cell_by
);

  localparam int SW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [SW-1:0]     STEP_LAST  = SW'(CELL_PX - 1);
  localparam logic [3:0]        INIT_CX    = 4'(INIT_GX);
  localparam logic [3:0]        INIT_CY    = 4'(INIT_GY);
  localparam logic [7:0]        INIT_PX    = 8'(INIT_GX * CELL_PX);
  localparam logic [6:0]        INIT_PY    = 7'(INIT_GY * CELL_PX);
  localparam logic [1:0]        INIT_FACE  = 2'(INIT_DIR);
  localparam logic signed [4:0] GRID_MAX_S = 5'(GRID_MAX);

  state_t        r_state;
  logic [7:0]    r_pos_x;
  logic [6:0]    r_pos_y;
  logic [1:0]    r_facing;
  logic          r_moving;
  logic [3:0]    r_cell_ax, r_cell_ay, r_cell_bx, r_cell_by;
  logic [SW-1:0] r_step;

  cell_s_t w_nb;
  logic    w_legal;
  logic    w_start;
  logic    w_step;

  assign w_nb    = neighbour(r_cell_ax, r_cell_ay, cmd[1:0]);
  assign w_legal = !w_nb.x[4] && !w_nb.y[4] && (w_nb.x <= GRID_MAX_S) && (w_nb.y <= GRID_MAX_S);
  assign w_start = (r_state == ST_IDLE) && cmd[CMD_GO] && !kill && w_legal;

  // Ticks only count while moving; the accepting cycle's tick is deliberately dropped.
  tick_divider #(
    .STEP_DIV(STEP_DIV)
  ) u_div (
    .clk    (clk),
    .resetn (resetn),
    .i_clear(kill || w_start),
    .i_tick (tick && (r_state == ST_MOVE)),
    .o_step (w_step)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_pos_x   <= INIT_PX;
      r_pos_y   <= INIT_PY;
      r_facing  <= INIT_FACE;
      r_moving  <= 1'b0;
      r_cell_ax <= INIT_CX;
      r_cell_ay <= INIT_CY;
      r_cell_bx <= INIT_CX;
      r_cell_by <= INIT_CY;
      r_step    <= '0;
    end else if (kill) begin
      r_state   <= ST_IDLE;
      r_pos_x   <= INIT_PX;
      r_pos_y   <= INIT_PY;
      r_facing  <= INIT_FACE;
      r_moving  <= 1'b0;
      r_cell_ax <= INIT_CX;
      r_cell_ay <= INIT_CY;
      r_cell_bx <= INIT_CX;
      r_cell_by <= INIT_CY;
      r_step    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd[CMD_GO]) begin
            r_facing <= cmd[1:0];
            if (w_legal) begin
              r_cell_bx <= w_nb.x[3:0];
              r_cell_by <= w_nb.y[3:0];
              r_moving  <= 1'b1;
              r_step    <= '0;
              r_state   <= ST_MOVE;
            end
          end
        end
        ST_MOVE: begin
          if (w_step) begin
            case (r_facing)
              DIR_UP:    r_pos_y <= r_pos_y - 7'd1;
              DIR_DOWN:  r_pos_y <= r_pos_y + 7'd1;
              DIR_LEFT:  r_pos_x <= r_pos_x - 8'd1;
              DIR_RIGHT: r_pos_x <= r_pos_x + 8'd1;
              default: ;
            endcase
            if (r_step == STEP_LAST) begin
              r_cell_ax <= r_cell_bx;
              r_cell_ay <= r_cell_by;
              r_moving  <= 1'b0;
              r_step    <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pos_x   = r_pos_x;
  assign pos_y   = r_pos_y;
  assign facing  = r_facing;
  assign moving  = r_moving;
  assign cell_ax = r_cell_ax;
  assign cell_ay = r_cell_ay;
  assign cell_bx = r_cell_bx;
  assign cell_by = r_cell_by;

endmodule

// File: tb/tb_tank_mover.sv
// Bench for tank_mover: two instances (STEP_DIV 1 and 2) checked every cycle against a
// tick-counting reference model, plus a vector table and directed boundary sequences.
module tb_tank_mover;

  typedef struct {
    int ax, ay, bx, by, face, mov, ticks;
  } mdl_t;

  typedef struct {
    bit       tk;
    bit [2:0] cmd;
    bit       kl;
    int       px, py, face, mov, ax, ay, bx, by;
  } vec_t;

  logic       clk;
  logic       resetn;
  logic       tick1, kill1, tick2, kill2;
  logic [2:0] cmd1, cmd2;

  logic [7:0] px1, px2;
  logic [6:0] py1, py2;
  logic [1:0] f1, f2;
  logic       mv1, mv2;
  logic [3:0] ax1, ay1, bx1, by1, ax2, ay2, bx2, by2;

  logic [33:0] act1, act2;
  assign act1 = {px1, py1, f1, mv1, ax1, ay1, bx1, by1};
  assign act2 = {px2, py2, f2, mv2, ax2, ay2, bx2, by2};

  int   n_chk  = 0;
  int   n_fail = 0;
  mdl_t m1, m2, i1, i2;
  vec_t vt[10];

  tank_mover #(
    .CELL_PX(9), .GRID_MAX(12), .INIT_GX(1), .INIT_GY(1), .INIT_DIR(0), .STEP_DIV(1)
  ) dut1 (
    .clk(clk), .resetn(resetn), .tick(tick1), .cmd(cmd1), .kill(kill1),
    .pos_x(px1), .pos_y(py1), .facing(f1), .moving(mv1),
    .cell_ax(ax1), .cell_ay(ay1), .cell_bx(bx1), .cell_by(by1)
  );

  tank_mover #(
    .CELL_PX(9), .GRID_MAX(12), .INIT_GX(0), .INIT_GY(0), .INIT_DIR(2), .STEP_DIV(2)
  ) dut2 (
    .clk(clk), .resetn(resetn), .tick(tick2), .cmd(cmd2), .kill(kill2),
    .pos_x(px2), .pos_y(py2), .facing(f2), .moving(mv2),
    .cell_ax(ax2), .cell_ay(ay2), .cell_bx(bx2), .cell_by(by2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] pack(int x, int y, int f, int mv, int ax, int ay, int bx, int by);
    return {8'(x), 7'(y), 2'(f), 1'(mv), 4'(ax), 4'(ay), 4'(bx), 4'(by)};
  endfunction

  // Reference: a move is just a count of ticks; position is start cell plus ticks/STEP_DIV pixels.
  function automatic mdl_t mdl_next(mdl_t m, bit tk, bit [2:0] c, bit k, int sd, mdl_t init);
    mdl_t n;
    int tx, ty;
    n = m;
    if (k) return init;
    if (m.mov == 0) begin
      if (c[2]) begin
        n.face = int'(c[1:0]);
        tx = m.ax + ((c[1:0] == 2'd3) ? 1 : (c[1:0] == 2'd2) ? -1 : 0);
        ty = m.ay + ((c[1:0] == 2'd1) ? 1 : (c[1:0] == 2'd0) ? -1 : 0);
        if (tx >= 0 && tx <= 12 && ty >= 0 && ty <= 12) begin
          n.bx = tx; n.by = ty; n.mov = 1; n.ticks = 0;
        end
      end
    end else if (tk) begin
      n.ticks = m.ticks + 1;
      if (n.ticks == 9 * sd) begin
        n.ax = n.bx; n.ay = n.by; n.mov = 0; n.ticks = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [33:0] exp_out(mdl_t m, int sd);
    int off, x, y;
    off = (m.mov != 0) ? m.ticks / sd : 0;
    x = m.ax * 9 + ((m.face == 3) ? off : 0) - ((m.face == 2) ? off : 0);
    y = m.ay * 9 + ((m.face == 1) ? off : 0) - ((m.face == 0) ? off : 0);
    return pack(x, y, m.face, m.mov, m.ax, m.ay, m.bx, m.by);
  endfunction

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s t=%0t got x=%0d y=%0d face=%0d mov=%0d a=(%0d,%0d) b=(%0d,%0d) want x=%0d y=%0d face=%0d mov=%0d a=(%0d,%0d) b=(%0d,%0d)",
                 name, $time, act[33:26], act[25:19], act[18:17], act[16], act[15:12], act[11:8],
                 act[7:4], act[3:0], exp[33:26], exp[25:19], exp[18:17], exp[16], exp[15:12],
                 exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    if (!resetn) begin
      m1 = i1; m2 = i2;
    end else begin
      m1 = mdl_next(m1, tick1, cmd1, kill1, 1, i1);
      m2 = mdl_next(m2, tick2, cmd2, kill2, 2, i2);
    end
    #1;
    chk("model1", act1, exp_out(m1, 1));
    chk("model2", act2, exp_out(m2, 2));
  endtask

  task automatic d1(input logic t, input logic [2:0] c, input logic k);
    tick1 = t; cmd1 = c; kill1 = k; tick2 = 1'b0; cmd2 = 3'b000; kill2 = 1'b0;
    clk_cycle();
  endtask

  task automatic d2(input logic t, input logic [2:0] c, input logic k);
    tick2 = t; cmd2 = c; kill2 = k; tick1 = 1'b0; cmd1 = 3'b000; kill1 = 1'b0;
    clk_cycle();
  endtask

  task automatic move1(input logic [1:0] dir);
    d1(1'b0, {1'b1, dir}, 1'b0);
    for (int i = 0; i < 12 && m1.mov != 0; i++) d1(1'b1, 3'b000, 1'b0);
  endtask

  initial begin
    int ticks;
    i1 = '{1, 1, 1, 1, 0, 0, 0};
    i2 = '{0, 0, 0, 0, 2, 0, 0};
    m1 = i1; m2 = i2;
    resetn = 1'b0;
    tick1 = 1'b0; cmd1 = 3'b000; kill1 = 1'b0;
    tick2 = 1'b0; cmd2 = 3'b000; kill2 = 1'b0;

    vt[0] = '{1'b0, 3'b111, 1'b0, 9, 9, 3, 1, 1, 1, 2, 1};
    for (int k = 1; k <= 8; k++) vt[k] = '{1'b1, 3'b000, 1'b0, 9 + k, 9, 3, 1, 1, 1, 2, 1};
    vt[9] = '{1'b1, 3'b000, 1'b0, 18, 9, 3, 0, 2, 1, 2, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset1", act1, pack(9, 9, 0, 0, 1, 1, 1, 1));
    chk("reset2", act2, pack(0, 0, 2, 0, 0, 0, 0, 0));
    resetn = 1'b1;

    // Right move from (1,1), one pixel per tick.
    for (int k = 0; k < 10; k++) begin
      d1(vt[k].tk, vt[k].cmd, vt[k].kl);
      chk("vec", act1, pack(vt[k].px, vt[k].py, vt[k].face, vt[k].mov,
                            vt[k].ax, vt[k].ay, vt[k].bx, vt[k].by));
    end

    // Command arriving mid-move is ignored.
    move1(2'd3); move1(2'd1); move1(2'd1);
    d1(1'b0, 3'b101, 1'b0);
    repeat (4) d1(1'b1, 3'b000, 1'b0);
    d1(1'b1, 3'b110, 1'b0);
    chk("mid_cmd_ignored", act1, pack(27, 32, 1, 1, 3, 3, 3, 4));
    repeat (4) d1(1'b1, 3'b000, 1'b0);
    chk("down_done", act1, pack(27, 36, 1, 0, 3, 4, 3, 4));

    // Kill beats tick and cmd in the same cycle.
    d1(1'b0, 3'b111, 1'b0);
    repeat (3) d1(1'b1, 3'b000, 1'b0);
    d1(1'b1, 3'b111, 1'b1);
    chk("kill", act1, pack(9, 9, 0, 0, 1, 1, 1, 1));
    d1(1'b1, 3'b000, 1'b0);
    chk("kill_idle_tick", act1, pack(9, 9, 0, 0, 1, 1, 1, 1));

    // Grid boundary guards.
    move1(2'd2);
    d1(1'b0, 3'b110, 1'b0);
    chk("edge_left", act1, pack(0, 9, 2, 0, 0, 1, 0, 1));
    move1(2'd0);
    d1(1'b0, 3'b100, 1'b0);
    chk("edge_up", act1, pack(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (5) move1(2'd1);
    d1(1'b0, 3'b110, 1'b0);
    chk("edge_left_y5", act1, pack(0, 45, 2, 0, 0, 5, 0, 5));
    repeat (12) move1(2'd3);
    d1(1'b0, 3'b111, 1'b0);
    chk("edge_right", act1, pack(108, 45, 3, 0, 12, 5, 12, 5));
    repeat (7) move1(2'd1);
    d1(1'b0, 3'b101, 1'b0);
    chk("edge_down", act1, pack(108, 108, 1, 0, 12, 12, 12, 12));
    d1(1'b0, 3'b000, 1'b1);

    // STEP_DIV=2: one pixel per two ticks, 18 ticks per cell.
    d2(1'b0, 3'b111, 1'b0);
    chk("go2", act2, pack(0, 0, 3, 1, 0, 0, 1, 0));
    ticks = 0;
    for (int i = 0; i < 80 && mv2 === 1'b1; i++) begin
      if (i % 2 == 0) begin
        d2(1'b1, 3'b000, 1'b0);
        ticks++;
        if (mv2 === 1'b1) chk_int("px2_step", int'(px2), ticks / 2);
      end else begin
        d2(1'b0, 3'b000, 1'b0);
      end
    end
    chk_int("ticks2", ticks, 18);
    chk("done2", act2, pack(9, 0, 3, 0, 1, 0, 1, 0));

    // Asynchronous reset in the middle of a move.
    d2(1'b0, 3'b111, 1'b0);
    repeat (5) d2(1'b1, 3'b000, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset1", act1, pack(9, 9, 0, 0, 1, 1, 1, 1));
    chk("areset2", act2, pack(0, 0, 2, 0, 0, 0, 0, 0));
    d1(1'b0, 3'b000, 1'b0);
    resetn = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      tick1 = ($urandom_range(0, 3) != 0);
      cmd1  = ($urandom_range(0, 2) == 0) ? {1'b1, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 3));
      kill1 = ($urandom_range(0, 79) == 0);
      tick2 = ($urandom_range(0, 3) != 0);
      cmd2  = ($urandom_range(0, 2) == 0) ? {1'b1, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 3));
      kill2 = ($urandom_range(0, 79) == 0);
      clk_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
